int_source_dev: RTL and testbench
=================================

Name: int_source_dev

Overview:
- Memory-mapped interrupt source on the CPU's peripheral bus: the device that raises the external `interrupt` line into the CPU.
- The CPU side (exception entry, handler, acknowledge store) already exists. This block is the device end of that handshake.
- Raises `interrupt` on one of three events: a programmable countdown, a periodic countdown, or a match of the CPU's macroscopic PC.
- Clears `interrupt` when the CPU stores to the acknowledge word at BASE_ADDR.

Parameters:
- BASE_ADDR, 32'h0000_7f20: word address of the ACK/STATUS register. Register window is BASE_ADDR..BASE_ADDR+0x10.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  32  bus byte address. Bits [1:0] are ignored for decode.
- byteen  in  4  byte write enables. Any bit set means a write.
- wdata  in  32  write data, byte lanes aligned to byteen.
- rdata  out  32  combinational read data for addr.
- macroscopic_pc  in  32  CPU macroscopic PC. Compared with bits [1:0] masked.
- interrupt  out  1  interrupt request to the CPU. Equals pending & CTRL.IM.

Behaviour:
- Register map (word offset from BASE_ADDR):
  - +0x0 ACK/STATUS: write of any value clears pending. Read returns {29'b0, busy, EN, pending}.
  - +0x4 CTRL: [0] EN, [2:1] MODE, [3] IM. Upper bits read as 0.
  - +0x8 PRESET: R/W.
  - +0xC COUNT: read-only; writes ignored.
  - +0x10 TARGET: R/W. Bits [1:0] are stored as 0.
- Writes merge per byte lane: only lanes with byteen set are updated. Addresses outside the window are ignored and read as 0.
- MODE encoding:
  - 00: one-shot countdown.
  - 01: periodic countdown.
  - 10: PC match.
  - 11: reserved, behaves as EN=0.
- Reset: CTRL, PRESET, COUNT, TARGET and pending all 0. State IDLE. interrupt=0. Reset mid-operation aborts any count or watch immediately.
- FSM states: IDLE, LOAD, CNT, WATCH. busy=1 in any state except IDLE.
- IDLE:
  - EN=1 with MODE 00 or 01 -> LOAD.
  - EN=1 with MODE 10 -> WATCH.
  - Otherwise stay.
- LOAD: COUNT<=PRESET, -> CNT.
- CNT:
  - If COUNT>1: COUNT<=COUNT-1.
  - Else (COUNT is 0 or 1): COUNT<=0 and set pending.
    - MODE 00: clear EN, -> IDLE.
    - MODE 01: -> LOAD (reload PRESET).
- WATCH: when (macroscopic_pc & ~3)==TARGET, set pending, clear EN, -> IDLE. Fires once per arming.
- Latency: with the CTRL write (EN=1, countdown mode) at edge E0 and PRESET=N≥1, pending rises at edge E(N+2). PRESET=0 behaves as N=1.
- Periodic period: N+1 cycles between consecutive pending sets (N≥1).
- Leaving the FSM:
  - EN=0 written by the CPU, or MODE changed to 11: -> IDLE at the next edge. COUNT holds its value.
  - Any other MODE change mid-run takes effect only after the FSM returns to IDLE.
- PRESET written during CNT does not affect the running COUNT. It is used at the next LOAD.
- Simultaneous events on the same edge:
  - Ack and pending-set: set wins, pending stays 1. No event is lost.
  - CPU CTRL write and hardware EN clear: the CPU write wins.
- IM=0: pending still latches, interrupt stays 0. Setting IM later raises interrupt the same cycle (combinational AND).
- pending is sticky until acknowledged. It does not count multiple events.

Test Plan:
- Reset held 2 cycles, then released -> interrupt=0, all reads 0, STATUS=0.
- PRESET=5, then CTRL=0x9 (EN, one-shot, IM) at E0 -> interrupt rises after E7, EN reads 0. A store to BASE_ADDR at the next edge -> interrupt=0 one edge later.
- PRESET=3, CTRL=0xB (periodic) -> pending set at E5, E9, E13. Ack issued on the same edge as the E9 set -> pending remains 1.
- TARGET=0x3010, CTRL=0xD (PC match) -> interrupt rises on the edge where macroscopic_pc=0x3012 (masked match). A later revisit of 0x3010 after ack does not re-fire.
- byteen=4'b0010 write of 0xAABBCCDD to PRESET (initial 0) -> PRESET reads 0x0000CC00. Write to COUNT and to BASE_ADDR+0x20 -> no state change.
- Mid-count: CTRL EN cleared while COUNT=2 -> IDLE, COUNT holds 2, no interrupt. Reset asserted during WATCH -> interrupt=0 and all registers 0 on the next edge.

Source files
------------

// File: rtl/int_source_dev.sv
// ----------------------------------------------------------------------------
// int_source_dev
//
// Memory-mapped interrupt source on the CPU peripheral bus. Raises `interrupt`
// on a one-shot countdown, a periodic countdown, or a match of the CPU
// macroscopic PC. A store of any value to the ACK word clears the request.
//
// Register window (byte offsets from BASE_ADDR):
//   +0x00 ACK/STATUS  W: clear pending   R: {29'b0, busy, EN, pending}
//   +0x04 CTRL        [0] EN, [2:1] MODE, [3] IM
//   +0x08 PRESET      countdown reload value
//   +0x0C COUNT       running count, read-only
//   +0x10 TARGET      PC match address, bits [1:0] always 0
//
// Ports:
//   clk             system clock, rising edge
//   reset           synchronous, active-high reset
//   addr            bus byte address, bits [1:0] ignored
//   byteen          byte write enables, any bit set is a write
//   wdata           write data, byte lanes aligned to byteen
//   rdata           combinational read data for addr
//   macroscopic_pc  CPU macroscopic PC, bits [1:0] ignored
//   interrupt       pending & CTRL.IM
// ----------------------------------------------------------------------------
module int_source_dev #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7f20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [31:0] macroscopic_pc,
    output logic        interrupt
);

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;

    localparam logic [1:0] MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] MODE_PERIODIC = 2'b01;
    localparam logic [1:0] MODE_PCMATCH  = 2'b10;
    localparam logic [1:0] MODE_RSVD     = 2'b11;

    localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CNT   = 2'd2,
        WATCH = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state, state_nx;
    logic        en, im;
    logic [1:0]  mode;
    // Mode captured when the FSM leaves IDLE; later MODE writes (other than
    // to the reserved encoding) only matter once the FSM is back in IDLE.
    logic [1:0]  run_mode, run_mode_nx;
    logic [31:0] preset;
    logic [31:0] count, count_nx;
    logic [31:0] target;
    logic        pending;

    logic        hw_set;     // FSM event: set pending this edge
    logic        hw_clr_en;  // FSM event: clear EN this edge
    logic        abort;
    logic        pc_hit;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [29:0] word_addr;
    logic        wr;
    logic        sel_ack, sel_ctrl, sel_preset, sel_count, sel_target;

    assign word_addr  = addr[31:2];
    assign wr         = |byteen;
    assign sel_ack    = (word_addr == BASE_WORD);
    assign sel_ctrl   = (word_addr == BASE_WORD + 30'd1);
    assign sel_preset = (word_addr == BASE_WORD + 30'd2);
    assign sel_count  = (word_addr == BASE_WORD + 30'd3);
    assign sel_target = (word_addr == BASE_WORD + 30'd4);

    logic wr_ack, wr_ctrl, wr_preset, wr_target;
    assign wr_ack    = wr & sel_ack;
    // All CTRL fields live in byte lane 0; a CTRL store without lane 0
    // touches nothing and so does not override a hardware EN clear.
    assign wr_ctrl   = byteen[0] & sel_ctrl;
    assign wr_preset = wr & sel_preset;
    assign wr_target = wr & sel_target;

    // Per-lane write merge for the 32-bit registers.
    logic [31:0] preset_merged, target_merged;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        assign preset_merged[l*LANE_W +: LANE_W] =
            byteen[l] ? wdata[l*LANE_W +: LANE_W] : preset[l*LANE_W +: LANE_W];
        assign target_merged[l*LANE_W +: LANE_W] =
            byteen[l] ? wdata[l*LANE_W +: LANE_W] : target[l*LANE_W +: LANE_W];
    end

    // ------------------------------------------------------------------
    // FSM next-state
    // ------------------------------------------------------------------
    assign abort  = !en || (mode == MODE_RSVD);
    assign pc_hit = ({macroscopic_pc[31:2], 2'b00} == target);

    always_comb begin
        state_nx    = state;
        count_nx    = count;
        run_mode_nx = run_mode;
        hw_set      = 1'b0;
        hw_clr_en   = 1'b0;

        case (state)
            IDLE: begin
                if (en) begin
                    if (mode == MODE_ONESHOT || mode == MODE_PERIODIC) begin
                        state_nx    = LOAD;
                        run_mode_nx = mode;
                    end else if (mode == MODE_PCMATCH) begin
                        state_nx    = WATCH;
                        run_mode_nx = mode;
                    end
                end
            end

            LOAD: begin
                if (abort) begin
                    state_nx = IDLE;
                end else begin
                    count_nx = preset;
                    state_nx = CNT;
                end
            end

            CNT: begin
                if (abort) begin
                    state_nx = IDLE;          // COUNT holds
                end else if (count > 32'd1) begin
                    count_nx = count - 32'd1;
                end else begin
                    // COUNT of 0 or 1 terminates, so PRESET=0 acts as 1.
                    count_nx = '0;
                    hw_set   = 1'b1;
                    if (run_mode == MODE_PERIODIC) begin
                        state_nx = LOAD;
                    end else begin
                        hw_clr_en = 1'b1;
                        state_nx  = IDLE;
                    end
                end
            end

            WATCH: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (pc_hit) begin
                    // Disarm so the same address cannot fire again.
                    hw_set    = 1'b1;
                    hw_clr_en = 1'b1;
                    state_nx  = IDLE;
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            run_mode <= MODE_ONESHOT;
            en       <= 1'b0;
            mode     <= MODE_ONESHOT;
            im       <= 1'b0;
            preset   <= '0;
            count    <= '0;
            target   <= '0;
            pending  <= 1'b0;
        end else begin
            state    <= state_nx;
            run_mode <= run_mode_nx;
            count    <= count_nx;

            // CPU store to CTRL wins over the FSM clearing EN.
            if (wr_ctrl) begin
                en   <= wdata[0];
                mode <= wdata[2:1];
                im   <= wdata[3];
            end else if (hw_clr_en) begin
                en   <= 1'b0;
            end

            if (wr_preset) preset <= preset_merged;
            if (wr_target) target <= {target_merged[31:2], 2'b00};

            // A new event on the same edge as an ACK keeps pending set.
            if (hw_set)      pending <= 1'b1;
            else if (wr_ack) pending <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic busy;
    assign busy      = (state != IDLE);
    assign interrupt = pending & im;

    always_comb begin
        rdata = '0;
        if (sel_ack)         rdata = {29'b0, busy, en, pending};
        else if (sel_ctrl)   rdata = {28'b0, im, mode, en};
        else if (sel_preset) rdata = preset;
        else if (sel_count)  rdata = count;
        else if (sel_target) rdata = target;
    end

    // Address/PC low bits are ignored by design.
    logic unused_bits;
    assign unused_bits = &{1'b0, addr[1:0], macroscopic_pc[1:0], target_merged[1:0]};

endmodule

// File: tb/tb_int_source_dev.sv
module tb_int_source_dev;

  localparam logic [31:0] BASE = 32'h0000_7f20;
  localparam logic [31:0] PC_IDLE = 32'hFFFF_0000;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] macroscopic_pc;
  logic        interrupt;

  int checks = 0;
  int errors = 0;

  int_source_dev #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .addr(addr), .byteen(byteen), .wdata(wdata),
    .rdata(rdata), .macroscopic_pc(macroscopic_pc), .interrupt(interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (spec rules, per edge) ----------------
  // Activity: 0 none, 1 about to reload, 2 counting, 3 watching PC.
  int          m_act;
  logic        m_en, m_im, m_pend;
  logic [1:0]  m_mode, m_run;
  logic [31:0] m_preset, m_count, m_target;

  task automatic model_step(input logic r, input logic [31:0] a, input logic [3:0] be,
                            input logic [31:0] wd, input logic [31:0] pc);
    int act;
    logic setp, clr;
    logic [31:0] cnt, off;
    act = m_act; cnt = m_count; setp = 0; clr = 0;
    if (r) begin
      m_act = 0; m_en = 0; m_im = 0; m_pend = 0; m_mode = 0; m_run = 0;
      m_preset = 0; m_count = 0; m_target = 0;
      return;
    end
    if (m_act == 0) begin
      if (m_en && m_mode != 2'd3) begin
        m_run = m_mode;
        act = (m_mode == 2'd2) ? 3 : 1;
      end
    end else if (!m_en || m_mode == 2'd3) begin
      act = 0;
    end else if (m_act == 1) begin
      cnt = m_preset; act = 2;
    end else if (m_act == 2) begin
      if (m_count > 1) cnt = m_count - 1;
      else begin
        cnt = 0; setp = 1;
        if (m_run == 2'd1) act = 1;
        else begin clr = 1; act = 0; end
      end
    end else if ((pc & ~32'd3) == m_target) begin
      setp = 1; clr = 1; act = 0;
    end
    if (clr) m_en = 0;
    off = {a[31:2], 2'b00} - BASE;
    if (setp) m_pend = 1;
    else if (be != 0 && off == 0) m_pend = 0;
    if (be != 0) begin
      if (off == 4 && be[0]) begin
        m_en = wd[0]; m_mode = wd[2:1]; m_im = wd[3];
      end
      for (int l = 0; l < 4; l++) begin
        if (be[l] && off == 8)  m_preset[l*8 +: 8] = wd[l*8 +: 8];
        if (be[l] && off == 16) m_target[l*8 +: 8] = wd[l*8 +: 8];
      end
      m_target[1:0] = 2'b00;
    end
    m_act = act; m_count = cnt;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] off;
    off = {a[31:2], 2'b00} - BASE;
    case (off)
      32'd0:  return {29'b0, m_act != 0, m_en, m_pend};
      32'd4:  return {28'b0, m_im, m_mode, m_en};
      32'd8:  return m_preset;
      32'd12: return m_count;
      32'd16: return m_target;
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock edge with the given bus/PC inputs; model advances in lockstep.
  task automatic cycle(input logic r, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd, input logic [31:0] pc);
    reset = r; addr = a; byteen = be; wdata = wd; macroscopic_pc = pc;
    model_step(r, a, be, wd, pc);
    @(posedge clk);
    #1;
    byteen = 4'h0; reset = 1'b0;
  endtask

  task automatic idle(input int n, input logic [31:0] pc);
    for (int i = 0; i < n; i++) cycle(1'b0, BASE, 4'h0, 32'h0, pc);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] wd);
    cycle(1'b0, BASE + off, 4'hF, wd, PC_IDLE);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    addr = a; byteen = 4'h0;
    #1;
    v = rdata;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] ra;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [31:0] v;
    int offs[7];

    tbl[0]  = '{BASE + 8,  4'b0010, 32'hAABBCCDD, BASE + 8,  32'h0000CC00};
    tbl[1]  = '{BASE + 8,  4'b1001, 32'h11223344, BASE + 8,  32'h1100CC44};
    tbl[2]  = '{BASE + 12, 4'b1111, 32'hFFFFFFFF, BASE + 12, 32'h00000000};
    tbl[3]  = '{BASE + 32, 4'b1111, 32'hFFFFFFFF, BASE + 32, 32'h00000000};
    tbl[4]  = '{BASE + 16, 4'b1111, 32'h00003013, BASE + 16, 32'h00003010};
    tbl[5]  = '{BASE + 18, 4'b0100, 32'h00550000, BASE + 16, 32'h00553010};
    tbl[6]  = '{BASE + 4,  4'b1111, 32'hFFFFFFFE, BASE + 4,  32'h0000000E};
    tbl[7]  = '{BASE + 4,  4'b0010, 32'h0000FF01, BASE + 4,  32'h0000000E};
    tbl[8]  = '{BASE + 4,  4'b0001, 32'h00000008, BASE + 4,  32'h00000008};
    tbl[9]  = '{BASE - 4,  4'b1111, 32'hFFFFFFFF, BASE,      32'h00000000};
    tbl[10] = '{BASE + 8,  4'b1111, 32'h00000000, BASE + 8,  32'h00000000};
    tbl[11] = '{BASE + 20, 4'b1111, 32'h12345678, BASE + 20, 32'h00000000};
    offs = '{0, 4, 8, 12, 16, 32, -4};

    reset = 1'b1; addr = BASE; byteen = 4'h0; wdata = 0; macroscopic_pc = PC_IDLE;

    // ---- reset held 2 cycles ----
    cycle(1'b1, BASE, 4'h0, 0, PC_IDLE);
    cycle(1'b1, BASE, 4'h0, 0, PC_IDLE);
    idle(1, PC_IDLE);
    chk("reset_irq", {31'b0, interrupt}, 0);
    for (int k = 0; k < 5; k++) begin
      rd(BASE + 32'(k * 4), v);
      chk($sformatf("reset_reg%0d", k), v, 0);
    end

    // ---- one-shot PRESET=5 ----
    wr(8, 5);
    wr(4, 32'h9);                       // E0
    idle(6, PC_IDLE);                   // E1..E6
    chk("oneshot_e6_irq", {31'b0, interrupt}, 0);
    idle(1, PC_IDLE);                   // E7
    chk("oneshot_e7_irq", {31'b0, interrupt}, 1);
    rd(BASE + 4, v); chk("oneshot_ctrl", v, 32'h8);
    rd(BASE, v);     chk("oneshot_status", v, 32'h1);
    wr(0, 32'hDEAD);
    chk("oneshot_ack_irq", {31'b0, interrupt}, 0);

    // ---- periodic PRESET=3 ----
    wr(8, 3);
    wr(4, 32'hB);                       // E0
    idle(4, PC_IDLE);                   // E1..E4
    rd(BASE, v); chk("per_e4_pend", {31'b0, v[0]}, 0);
    idle(1, PC_IDLE);                   // E5
    rd(BASE, v); chk("per_e5_pend", {31'b0, v[0]}, 1);
    wr(0, 0);                           // E6 ack
    rd(BASE, v); chk("per_e6_ack", {31'b0, v[0]}, 0);
    idle(2, PC_IDLE);                   // E7..E8
    wr(0, 0);                           // E9 ack coincides with set
    rd(BASE, v); chk("per_e9_setwins", {31'b0, v[0]}, 1);
    wr(0, 0);                           // E10
    idle(2, PC_IDLE);                   // E11..E12
    rd(BASE, v); chk("per_e12_pend", {31'b0, v[0]}, 0);
    idle(1, PC_IDLE);                   // E13
    rd(BASE, v); chk("per_e13_pend", {31'b0, v[0]}, 1);
    wr(4, 32'h8);
    wr(0, 0);
    idle(2, PC_IDLE);
    chk("per_stop_irq", {31'b0, interrupt}, 0);

    // ---- PC match ----
    wr(16, 32'h3010);
    wr(4, 32'hD);                       // E0
    idle(4, 32'h3000);                  // E1..E4
    chk("pc_nomatch_irq", {31'b0, interrupt}, 0);
    idle(1, 32'h3012);                  // E5
    chk("pc_match_irq", {31'b0, interrupt}, 1);
    rd(BASE + 4, v); chk("pc_ctrl", v, 32'hC);
    wr(0, 0);
    idle(3, 32'h3010);
    chk("pc_revisit_irq", {31'b0, interrupt}, 0);

    // ---- EN cleared mid-count ----
    wr(8, 5);
    wr(4, 32'h9);                       // E0
    idle(4, PC_IDLE);                   // E1..E4
    wr(4, 32'h8);                       // E5: COUNT becomes 2, EN=0
    idle(1, PC_IDLE);                   // E6: back to IDLE
    rd(BASE + 12, v); chk("mid_count", v, 2);
    idle(8, PC_IDLE);
    rd(BASE + 12, v); chk("mid_count_hold", v, 2);
    rd(BASE, v);      chk("mid_status", v, 0);
    chk("mid_irq", {31'b0, interrupt}, 0);

    // ---- reset during WATCH ----
    wr(8, 7);
    wr(16, 32'h4000);
    wr(4, 32'hD);
    idle(2, 32'h5000);
    rd(BASE, v); chk("watch_busy", v, 32'h6);
    cycle(1'b1, BASE, 4'h0, 0, 32'h5000);
    chk("rst_watch_irq", {31'b0, interrupt}, 0);
    for (int k = 0; k < 5; k++) begin
      rd(BASE + 32'(k * 4), v);
      chk($sformatf("rst_watch_reg%0d", k), v, 0);
    end

    // ---- register access table ----
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, tbl[i].a, tbl[i].be, tbl[i].wd, PC_IDLE);
      rd(tbl[i].ra, v);
      chk($sformatf("tbl%0d", i), v, tbl[i].exp);
      chk($sformatf("tbl%0d_irq", i), {31'b0, interrupt}, 0);
    end

    // ---- randomized against the model ----
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a, w, pc;
      logic [3:0]  be;
      int sel;
      pc = 32'h100 + 32'($urandom_range(0, 11));
      sel = $urandom_range(0, 9);
      a = BASE + 32'(offs[$urandom_range(0, 6)]) + 32'($urandom_range(0, 3));
      be = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'hF;
      w = 32'($urandom_range(0, 6));
      if ({a[31:2], 2'b00} == BASE + 4) begin
        w = 32'($urandom_range(0, 15));
        if ($urandom_range(0, 3) != 0) w[0] = 1'b1;
      end else if ({a[31:2], 2'b00} == BASE + 16) begin
        w = 32'h100 + 32'($urandom_range(0, 11));
      end
      if ($urandom_range(0, 199) == 0)
        cycle(1'b1, a, 4'h0, 0, pc);
      else if (sel < 4)
        cycle(1'b0, a, 4'h0, 0, pc);
      else
        cycle(1'b0, a, be, w, pc);
      chk("rnd_irq", {31'b0, interrupt}, {31'b0, m_pend & m_im});
      a = BASE + 32'(offs[$urandom_range(0, 6)]);
      rd(a, v);
      chk("rnd_rdata", v, model_read(a));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
